// File: rtl/rv_fetch_ctrl.sv
// rv_fetch_ctrl -- instruction-fetch sequencer between the instruction memory
// bus and rv_fetch_buf.
//
// Issues one 32-bit word request at a time and pushes the returned halfwords
// into the fetch buffer: a double push normally, or a single push (upper
// halfword only) when the fetch address is halfword-misaligned after a
// redirect. A redirect that arrives while a request is outstanding parks the
// sequencer in DROP until the in-flight response is acked and discarded.
// Requests are only issued when the buffer guarantees room for two halfwords.
//
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_branch, i_branch_pc redirect pulse and halfword target address
//   o_mem_req, o_mem_addr word request and word address (state-only decode)
//   i_mem_ack, i_mem_data request accepted, returned word (same cycle)
//   o_push_single/double  buffer push strobes (combinational from the ack)
//   o_data_lo, o_data_hi  halves of i_mem_data
//   i_buf_not_full        buffer has >= 2 free halfwords next cycle
//   o_buf_flush, o_buf_pc buffer reset and the PC it restarts from
//
// Optional feature: define RV_FETCH_CTRL_STATS_EN to add the 32-bit wrapping
// counters o_cnt_fetch, o_cnt_drop and o_cnt_stall.

module rv_fetch_ctrl #(
    parameter int          IADDR_SPACE_BITS = 16,
    parameter int unsigned RESET_ADDR       = 0
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_branch,
    input  logic [IADDR_SPACE_BITS-1:1]   i_branch_pc,
    output logic                          o_mem_req,
    output logic [IADDR_SPACE_BITS-1:2]   o_mem_addr,
    input  logic                          i_mem_ack,
    input  logic [31:0]                   i_mem_data,
    output logic                          o_push_single,
    output logic                          o_push_double,
    output logic [15:0]                   o_data_lo,
    output logic [15:0]                   o_data_hi,
    input  logic                          i_buf_not_full,
    output logic                          o_buf_flush,
    output logic [IADDR_SPACE_BITS-1:1]   o_buf_pc
`ifdef RV_FETCH_CTRL_STATS_EN
    ,
    output logic [31:0]                   o_cnt_fetch,
    output logic [31:0]                   o_cnt_drop,
    output logic [31:0]                   o_cnt_stall
`endif
);

    typedef enum logic [1:0] {
        S_FLUSH,
        S_FETCH,
        S_STALL,
        S_DROP
    } state_t;

    // Reset target in halfword units; bit 0 of the byte address is dropped.
    localparam logic [31:0]                 RESET_ADDR_W = RESET_ADDR;
    localparam logic [IADDR_SPACE_BITS-1:1] RESET_PC     = RESET_ADDR_W[IADDR_SPACE_BITS-1:1];
    localparam logic [IADDR_SPACE_BITS-1:2] WORD_ONE     = {{(IADDR_SPACE_BITS-3){1'b0}}, 1'b1};

    state_t                        state;
    logic [IADDR_SPACE_BITS-1:1]   fetch_pc;
    logic [IADDR_SPACE_BITS-1:1]   target;
    logic                          push;

    // An ack in FETCH delivers data; a coincident redirect discards it.
    assign push          = (state == S_FETCH) && i_mem_ack && !i_branch;
    assign o_push_single = push &&  fetch_pc[1];
    assign o_push_double = push && !fetch_pc[1];
    assign o_data_lo     = i_mem_data[15:0];
    assign o_data_hi     = i_mem_data[31:16];

    // Request and address decode from registers only, so there is no
    // combinational path from any input to the memory bus.
    assign o_mem_req   = (state == S_FETCH) || (state == S_DROP);
    assign o_mem_addr  = fetch_pc[IADDR_SPACE_BITS-1:2];
    assign o_buf_flush = (state == S_FLUSH);
    assign o_buf_pc    = target;

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (i_reset) begin
            state    <= S_FLUSH;
            target   <= RESET_PC;
            fetch_pc <= RESET_PC;
        end else begin
            // A redirect always captures its target, whatever the state.
            if (i_branch) begin
                target <= i_branch_pc;
            end

            case (state)
                S_FLUSH: begin
                    fetch_pc <= target;
                    if (!i_branch) begin
                        state <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    if (i_branch) begin
                        // With the ack the response is simply not pushed;
                        // without it the outstanding request must be drained.
                        state <= i_mem_ack ? S_FLUSH : S_DROP;
                    end else if (i_mem_ack) begin
                        // Next fetch is always the following aligned word;
                        // the increment wraps modulo the address space.
                        fetch_pc <= {fetch_pc[IADDR_SPACE_BITS-1:2] + WORD_ONE, 1'b0};
                        state    <= i_buf_not_full ? S_FETCH : S_STALL;
                    end
                end

                S_STALL: begin
                    if (i_branch) begin
                        state <= S_FLUSH;
                    end else if (i_buf_not_full) begin
                        state <= S_FETCH;
                    end
                end

                S_DROP: begin
                    if (i_mem_ack) begin
                        state <= S_FLUSH;
                    end
                end

                default: state <= S_FLUSH;
            endcase
        end
    end

`ifdef RV_FETCH_CTRL_STATS_EN
    logic drop_ack;

    assign drop_ack = i_mem_ack &&
                      ((state == S_DROP) || ((state == S_FETCH) && i_branch));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_cnt_fetch <= '0;
            o_cnt_drop  <= '0;
            o_cnt_stall <= '0;
        end else begin
            if (push) begin
                o_cnt_fetch <= o_cnt_fetch + 32'd1;
            end
            if (drop_ack) begin
                o_cnt_drop <= o_cnt_drop + 32'd1;
            end
            if (state == S_STALL) begin
                o_cnt_stall <= o_cnt_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rv_fetch_ctrl.sv
// Testbench for rv_fetch_ctrl: one table of per-cycle vectors (inputs plus the
// outputs expected in that same cycle), driven through a scoreboard queue,
// followed by a hand-written stall/resume sequence.

module tb_rv_fetch_ctrl;

    logic         i_clk = 1'b0;
    logic         i_reset;
    logic         i_branch;
    logic [15:1]  i_branch_pc;
    logic         o_mem_req;
    logic [15:2]  o_mem_addr;
    logic         i_mem_ack;
    logic [31:0]  i_mem_data;
    logic         o_push_single;
    logic         o_push_double;
    logic [15:0]  o_data_lo;
    logic [15:0]  o_data_hi;
    logic         i_buf_not_full;
    logic         o_buf_flush;
    logic [15:1]  o_buf_pc;
`ifdef RV_FETCH_CTRL_STATS_EN
    logic [31:0]  o_cnt_fetch;
    logic [31:0]  o_cnt_drop;
    logic [31:0]  o_cnt_stall;
`endif

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    rv_fetch_ctrl #(
        .IADDR_SPACE_BITS (16),
        .RESET_ADDR       (0)
    ) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_branch       (i_branch),
        .i_branch_pc    (i_branch_pc),
        .o_mem_req      (o_mem_req),
        .o_mem_addr     (o_mem_addr),
        .i_mem_ack      (i_mem_ack),
        .i_mem_data     (i_mem_data),
        .o_push_single  (o_push_single),
        .o_push_double  (o_push_double),
        .o_data_lo      (o_data_lo),
        .o_data_hi      (o_data_hi),
        .i_buf_not_full (i_buf_not_full),
        .o_buf_flush    (o_buf_flush),
        .o_buf_pc       (o_buf_pc)
`ifdef RV_FETCH_CTRL_STATS_EN
        ,
        .o_cnt_fetch    (o_cnt_fetch),
        .o_cnt_drop     (o_cnt_drop),
        .o_cnt_stall    (o_cnt_stall)
`endif
    );

    typedef struct {
        logic        rst;
        logic        br;
        logic [15:1] bpc;
        logic        ack;
        logic [31:0] data;
        logic        nf;
        logic        ex_flush;
        logic [15:1] ex_bpc;
        logic        ex_req;
        logic [15:2] ex_addr;
        logic        ex_single;
        logic        ex_double;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    function automatic vec_t mk(logic rst, logic br, logic [15:1] bpc, logic ack,
                                logic [31:0] data, logic nf, logic ex_flush,
                                logic [15:1] ex_bpc, logic ex_req, logic [15:2] ex_addr,
                                logic ex_single, logic ex_double);
        vec_t v;
        v.rst = rst;           v.br = br;           v.bpc = bpc;
        v.ack = ack;           v.data = data;       v.nf = nf;
        v.ex_flush = ex_flush; v.ex_bpc = ex_bpc;   v.ex_req = ex_req;
        v.ex_addr = ex_addr;   v.ex_single = ex_single; v.ex_double = ex_double;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle: drive just after the rising edge, queue the expectation,
    // then sample mid-cycle and compare against the popped expectation.
    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        @(posedge i_clk);
        #1;
        i_reset        = v.rst;
        i_branch       = v.br;
        i_branch_pc    = v.bpc;
        i_mem_ack      = v.ack;
        i_mem_data     = v.data;
        i_buf_not_full = v.nf;
        sb.push_back(v);
        #3;
        e = sb.pop_front();
        check({tag, " flush"},  {31'd0, o_buf_flush},   {31'd0, e.ex_flush});
        check({tag, " req"},    {31'd0, o_mem_req},     {31'd0, e.ex_req});
        check({tag, " single"}, {31'd0, o_push_single}, {31'd0, e.ex_single});
        check({tag, " double"}, {31'd0, o_push_double}, {31'd0, e.ex_double});
        if (e.ex_flush)
            check({tag, " buf_pc"}, {17'd0, o_buf_pc}, {17'd0, e.ex_bpc});
        if (e.ex_req)
            check({tag, " addr"}, {18'd0, o_mem_addr}, {18'd0, e.ex_addr});
        if (e.ex_single || e.ex_double)
            check({tag, " data"}, {o_data_hi, o_data_lo}, e.data);
    endtask

    initial begin
        i_reset = 1'b1; i_branch = 1'b0; i_branch_pc = '0;
        i_mem_ack = 1'b0; i_mem_data = '0; i_buf_not_full = 1'b1;
        repeat (2) @(posedge i_clk);

        //           rst br bpc       ack data          nf  fl bpc_e     req addr      s  d
        tbl.push_back(mk(1, 0, 15'h000, 0, 32'h0,        1,  1, 15'h000,  0, 14'h000,  0, 0)); // reset held
        tbl.push_back(mk(0, 0, 15'h000, 0, 32'h0,        1,  1, 15'h000,  0, 14'h000,  0, 0)); // one FLUSH cycle
        tbl.push_back(mk(0, 0, 15'h000, 1, 32'h00130013, 1,  0, 15'h000,  1, 14'h000,  0, 1)); // first ack
        tbl.push_back(mk(0, 0, 15'h000, 0, 32'h0,        1,  0, 15'h000,  1, 14'h001,  0, 0)); // word 1
        tbl.push_back(mk(0, 1, 15'h083, 1, 32'hDEADBEEF, 1,  0, 15'h000,  1, 14'h001,  0, 0)); // branch+ack
        tbl.push_back(mk(0, 0, 15'h000, 0, 32'h0,        1,  1, 15'h083,  0, 14'h000,  0, 0));
        tbl.push_back(mk(0, 0, 15'h000, 1, 32'hABCD1234, 1,  0, 15'h000,  1, 14'h041,  1, 0)); // misaligned
        tbl.push_back(mk(0, 0, 15'h000, 1, 32'h11112222, 1,  0, 15'h000,  1, 14'h042,  0, 1)); // back-to-back
        tbl.push_back(mk(0, 1, 15'h00A, 0, 32'h0,        1,  0, 15'h000,  1, 14'h043,  0, 0)); // -> DROP
        tbl.push_back(mk(0, 0, 15'h000, 1, 32'h55556666, 1,  0, 15'h000,  1, 14'h043,  0, 0)); // dropped
        tbl.push_back(mk(0, 0, 15'h000, 0, 32'h0,        1,  1, 15'h00A,  0, 14'h000,  0, 0));
        tbl.push_back(mk(0, 1, 15'h100, 0, 32'h0,        1,  0, 15'h000,  1, 14'h005,  0, 0)); // word 5 pending
        tbl.push_back(mk(0, 0, 15'h000, 0, 32'h0,        1,  0, 15'h000,  1, 14'h005,  0, 0));
        tbl.push_back(mk(0, 0, 15'h000, 1, 32'h77778888, 1,  0, 15'h000,  1, 14'h005,  0, 0)); // late ack
        tbl.push_back(mk(0, 0, 15'h000, 0, 32'h0,        1,  1, 15'h100,  0, 14'h000,  0, 0));
        tbl.push_back(mk(0, 0, 15'h000, 1, 32'h9999AAAA, 0,  0, 15'h000,  1, 14'h080,  0, 1)); // full
        tbl.push_back(mk(0, 0, 15'h000, 0, 32'h0,        0,  0, 15'h000,  0, 14'h000,  0, 0));
        tbl.push_back(mk(0, 0, 15'h000, 0, 32'h0,        0,  0, 15'h000,  0, 14'h000,  0, 0));
        tbl.push_back(mk(0, 0, 15'h000, 0, 32'h0,        0,  0, 15'h000,  0, 14'h000,  0, 0));
        tbl.push_back(mk(0, 0, 15'h000, 0, 32'h0,        1,  0, 15'h000,  0, 14'h000,  0, 0)); // space back
        tbl.push_back(mk(0, 0, 15'h000, 0, 32'h0,        1,  0, 15'h000,  1, 14'h081,  0, 0));
        tbl.push_back(mk(0, 1, 15'h200, 1, 32'hBBBBCCCC, 1,  0, 15'h000,  1, 14'h081,  0, 0)); // branch+ack
        tbl.push_back(mk(0, 1, 15'h300, 0, 32'h0,        1,  1, 15'h200,  0, 14'h000,  0, 0)); // branch in FLUSH
        tbl.push_back(mk(0, 0, 15'h000, 0, 32'h0,        1,  1, 15'h300,  0, 14'h000,  0, 0));
        tbl.push_back(mk(0, 0, 15'h000, 0, 32'h0,        1,  0, 15'h000,  1, 14'h180,  0, 0));
        tbl.push_back(mk(1, 0, 15'h000, 0, 32'h0,        1,  0, 15'h000,  1, 14'h180,  0, 0)); // reset mid-req
        tbl.push_back(mk(0, 0, 15'h000, 1, 32'hEEEEFFFF, 1,  1, 15'h000,  0, 14'h000,  0, 0)); // stray ack
        tbl.push_back(mk(0, 0, 15'h000, 0, 32'h0,        1,  0, 15'h000,  1, 14'h000,  0, 0));
        tbl.push_back(mk(0, 1, 15'h7FFF,0, 32'h0,        1,  0, 15'h000,  1, 14'h000,  0, 0)); // to top halfword
        tbl.push_back(mk(0, 0, 15'h000, 1, 32'h12345678, 1,  0, 15'h000,  1, 14'h000,  0, 0));
        tbl.push_back(mk(0, 0, 15'h000, 0, 32'h0,        1,  1, 15'h7FFF, 0, 14'h000,  0, 0));
        tbl.push_back(mk(0, 0, 15'h000, 1, 32'hCAFEF00D, 1,  0, 15'h000,  1, 14'h3FFF, 1, 0)); // last word
        tbl.push_back(mk(0, 0, 15'h000, 0, 32'h0,        1,  0, 15'h000,  1, 14'h000,  0, 0)); // wrapped
        tbl.push_back(mk(0, 0, 15'h000, 1, 32'h0F0F1E1E, 0,  0, 15'h000,  1, 14'h000,  0, 1));
        tbl.push_back(mk(0, 1, 15'h010, 0, 32'h0,        0,  0, 15'h000,  0, 14'h000,  0, 0)); // branch in STALL
        tbl.push_back(mk(0, 0, 15'h000, 0, 32'h0,        1,  1, 15'h010,  0, 14'h000,  0, 0));
        tbl.push_back(mk(0, 0, 15'h000, 0, 32'h0,        1,  0, 15'h000,  1, 14'h008,  0, 0));

        foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i));

        // Stall/resume: ack with the buffer full, request stays low for three
        // cycles, space returns, then the next word is requested.
        apply(mk(0, 0, 15'h000, 1, 32'h24682468, 0, 0, 15'h000, 1, 14'h008, 0, 1), "stall ack");
        for (int k = 0; k < 3; k++)
            apply(mk(0, 0, 15'h000, 0, 32'h0, 0, 0, 15'h000, 0, 14'h000, 0, 0),
                  $sformatf("stall hold%0d", k));
        apply(mk(0, 0, 15'h000, 0, 32'h0, 1, 0, 15'h000, 0, 14'h000, 0, 0), "stall release");
        apply(mk(0, 0, 15'h000, 0, 32'h0, 1, 0, 15'h000, 1, 14'h009, 0, 0), "resume");

`ifdef RV_FETCH_CTRL_STATS_EN
        // Counters cleared by the mid-run reset; totals since then.
        check("cnt_fetch", o_cnt_fetch, 32'd3);
        check("cnt_drop",  o_cnt_drop,  32'd1);
        check("cnt_stall", o_cnt_stall, 32'd5);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
